// File: rtl/mpu_result_collector.sv
`default_nettype none
// ============================================================================
// mpu_result_collector: gathers tagged FMA results into an MxN buffer, then
// writes the buffer to the matrix register file one row per cycle.
// Optional feature macro: MPU_COLLECTOR_DUP_CHECK_EN (drop duplicate tags, flag dup_err).
// Revision: 1.0
// ============================================================================
module mpu_result_collector #(
   parameter int FP    = 32,
   parameter int M     = 3,
   parameter int N     = 3,
   parameter int MREGS = 8,
   localparam int MBITS           = $clog2(M) - 1,
   localparam int NBITS           = $clog2(N) - 1,
   localparam int MATRIX_REG_BITS = $clog2(MREGS) - 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [MATRIX_REG_BITS:0]   dest_addr,
   input  logic [MBITS:0]             m_in,
   input  logic [NBITS:0]             n_in,
   input  logic                       res_valid,
   output logic                       res_ready,
   input  logic [MBITS:0]             res_row,
   input  logic [NBITS:0]             res_col,
   input  logic [FP-1:0]              res_data,
   output logic                       reg_wr_en,
   output logic [MATRIX_REG_BITS:0]   reg_wr_addr,
   output logic [MBITS:0]             reg_wr_row,
   output logic [N*FP-1:0]            reg_wr_data,
   output logic                       busy,
   output logic                       done,
   output logic                       dup_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GATHER = 2'd1,
      WRITE  = 2'd2
   } state_t;

   localparam logic [MBITS:0] M_LIM = (MBITS+1)'(M);
   localparam logic [NBITS:0] N_LIM = (NBITS+1)'(N);

   state_t                   state;
   logic [MATRIX_REG_BITS:0] dest;
   logic [MBITS:0]           m_lat;
   logic [NBITS:0]           n_lat;
   logic [MBITS:0]           row_cnt;
   logic [M*N-1:0]           mask;
   logic [FP-1:0]            buffer [M][N];

   logic [MBITS:0]           m_clamp;
   logic [NBITS:0]           n_clamp;
   logic [M*N-1:0]           sel;
   logic [M*N-1:0]           act;
   logic [M*N-1:0]           mask_nxt;
   logic                     accept;
   logic                     in_range;
   logic                     dup_hit;
   logic                     wr_hit;
   logic                     all_in;

   always_comb begin
      m_clamp = m_in;
      if (m_in == '0)
         m_clamp = (MBITS+1)'(1);
      else if (m_in > M_LIM)
         m_clamp = M_LIM;
      n_clamp = n_in;
      if (n_in == '0)
         n_clamp = (NBITS+1)'(1);
      else if (n_in > N_LIM)
         n_clamp = N_LIM;
   end

   // sel: one-hot of the incoming tag; act: elements inside the latched m x n window
   always_comb begin
      sel = '0;
      act = '0;
      for (int r = 0; r < M; r++) begin
         for (int c = 0; c < N; c++) begin
            if (int'(res_row) == r && int'(res_col) == c)
               sel[r*N+c] = 1'b1;
            if (r < int'(m_lat) && c < int'(n_lat))
               act[r*N+c] = 1'b1;
         end
      end
      accept   = (state == GATHER) && res_valid;
      in_range = |(sel & act);
`ifdef MPU_COLLECTOR_DUP_CHECK_EN
      dup_hit  = in_range && |(sel & mask);
`else
      dup_hit  = 1'b0;
`endif
      wr_hit   = accept && in_range && !dup_hit;
      mask_nxt = wr_hit ? (mask | sel) : mask;
      all_in   = ((mask_nxt & act) == act);
   end

   always_comb begin
      res_ready   = (state == GATHER);
      busy        = (state != IDLE);
      reg_wr_en   = (state == WRITE);
      reg_wr_addr = (state == WRITE) ? dest : '0;
      reg_wr_row  = (state == WRITE) ? row_cnt : '0;
      reg_wr_data = '0;
      if (state == WRITE) begin
         for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
               if (r == int'(row_cnt) && c < int'(n_lat))
                  reg_wr_data[(N-1-c)*FP +: FP] = buffer[r][c];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         dest    <= '0;
         m_lat   <= '0;
         n_lat   <= '0;
         row_cnt <= '0;
         mask    <= '0;
         done    <= 1'b0;
         dup_err <= 1'b0;
         for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
               buffer[r][c] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dest    <= dest_addr;
                  m_lat   <= m_clamp;
                  n_lat   <= n_clamp;
                  row_cnt <= '0;
                  mask    <= '0;
                  dup_err <= 1'b0;
                  for (int r = 0; r < M; r++)
                     for (int c = 0; c < N; c++)
                        buffer[r][c] <= '0;
                  state   <= GATHER;
               end
            end
            GATHER: begin
               mask <= mask_nxt;
               if (wr_hit) begin
                  for (int r = 0; r < M; r++)
                     for (int c = 0; c < N; c++)
                        if (sel[r*N+c])
                           buffer[r][c] <= res_data;
               end
               if (accept && dup_hit)
                  dup_err <= 1'b1;
               // final accept and the move to WRITE land on the same edge
               if (all_in) begin
                  row_cnt <= '0;
                  state   <= WRITE;
               end
            end
            WRITE: begin
               if (row_cnt == m_lat - 1'b1) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  row_cnt <= row_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
